// File: rtl/vga_timing_pkg.sv
// Mode constants for the VGA sync generator: 640x480@60 defaults plus an 800x600@60 set.
// Also the helper that folds porch/sync widths into a line or frame total.
package vga_timing_pkg;

  localparam int VGA640_H_ACTIVE   = 640;
  localparam int VGA640_H_FP       = 16;
  localparam int VGA640_H_SYNC     = 96;
  localparam int VGA640_H_BP       = 48;
  localparam int VGA640_V_ACTIVE   = 480;
  localparam int VGA640_V_FP       = 10;
  localparam int VGA640_V_SYNC     = 2;
  localparam int VGA640_V_BP       = 33;
  localparam bit VGA640_H_SYNC_POL = 1'b0;
  localparam bit VGA640_V_SYNC_POL = 1'b0;

  localparam int VGA800_H_ACTIVE   = 800;
  localparam int VGA800_H_FP       = 40;
  localparam int VGA800_H_SYNC     = 128;
  localparam int VGA800_H_BP       = 88;
  localparam int VGA800_V_ACTIVE   = 600;
  localparam int VGA800_V_FP       = 1;
  localparam int VGA800_V_SYNC     = 4;
  localparam int VGA800_V_BP       = 23;
  localparam bit VGA800_H_SYNC_POL = 1'b1;
  localparam bit VGA800_V_SYNC_POL = 1'b1;

  function automatic int axisTotal(input int active, input int fp, input int sync, input int bp);
    return active + fp + sync + bp;
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// Wrapping 0..TOTAL-1 counter for one raster axis; count_next/wrap are combinational look-ahead.
// Advances only on step; resets to TOTAL-1 so the first step lands on 0.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter  int TOTAL = 800,
  localparam int W     = $clog2(TOTAL)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         step,
  output logic [W-1:0] count,
  output logic         wrap,
  output logic [W-1:0] count_next
);

  localparam logic [W-1:0] LAST = W'(TOTAL - 1);

  assign wrap = step && (count == LAST);

  always_comb begin
    count_next = count;
    if (step) count_next = (count == LAST) ? '0 : count + 1'b1;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) count <= LAST;
    else       count <= count_next;
  end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster/sync generator; flags decoded from next-state counters, zero skew.
// Advances one pixel per pix_en, holds everything otherwise; optional VGA_TIMING_FRAME_COUNT_EN adds frame_count.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter  int H_ACTIVE   = VGA640_H_ACTIVE,
  parameter  int H_FP       = VGA640_H_FP,
  parameter  int H_SYNC     = VGA640_H_SYNC,
  parameter  int H_BP       = VGA640_H_BP,
  parameter  int V_ACTIVE   = VGA640_V_ACTIVE,
  parameter  int V_FP       = VGA640_V_FP,
  parameter  int V_SYNC     = VGA640_V_SYNC,
  parameter  int V_BP       = VGA640_V_BP,
  parameter  bit H_SYNC_POL = VGA640_H_SYNC_POL,
  parameter  bit V_SYNC_POL = VGA640_V_SYNC_POL,
  localparam int H_TOTAL    = axisTotal(H_ACTIVE, H_FP, H_SYNC, H_BP),
  localparam int V_TOTAL    = axisTotal(V_ACTIVE, V_FP, V_SYNC, V_BP),
  localparam int X_W        = $clog2(H_TOTAL),
  localparam int Y_W        = $clog2(V_TOTAL)
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pix_en,
  output logic [X_W-1:0] counter_x,
  output logic [Y_W-1:0] counter_y,
  output logic           in_display_area,
  output logic           vga_h_sync,
  output logic           vga_v_sync,
  output logic           line_start,
  output logic           frame_start
`ifdef VGA_TIMING_FRAME_COUNT_EN
  ,
  output logic [15:0]    frame_count
`endif
);

  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : gParamCheck
    $error("vga_timing_gen: active, porch and sync widths must all be >= 1");
  end

  localparam logic [X_W-1:0] H_ACT      = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] H_SYNC_BEG = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] H_SYNC_END = X_W'(H_ACTIVE + H_FP + H_SYNC);
  localparam logic [Y_W-1:0] V_ACT      = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] V_SYNC_BEG = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] V_SYNC_END = Y_W'(V_ACTIVE + V_FP + V_SYNC);

  logic [X_W-1:0] xNext;
  logic [Y_W-1:0] yNext;
  logic           xWrap;
  logic           yWrap;

  vga_axis_counter #(.TOTAL(H_TOTAL)) uXCount (
    .clk        (clk),
    .reset      (reset),
    .step       (pix_en),
    .count      (counter_x),
    .wrap       (xWrap),
    .count_next (xNext)
  );

  vga_axis_counter #(.TOTAL(V_TOTAL)) uYCount (
    .clk        (clk),
    .reset      (reset),
    .step       (xWrap),
    .count      (counter_y),
    .wrap       (yWrap),
    .count_next (yNext)
  );

  // xWrap/yWrap already imply pix_en, so they mark entry to x==0 and (0,0).
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      in_display_area <= 1'b0;
      vga_h_sync      <= ~H_SYNC_POL;
      vga_v_sync      <= ~V_SYNC_POL;
      line_start      <= 1'b0;
      frame_start     <= 1'b0;
    end else if (pix_en) begin
      in_display_area <= (xNext < H_ACT) && (yNext < V_ACT);
      vga_h_sync      <= ((xNext >= H_SYNC_BEG) && (xNext < H_SYNC_END)) ? H_SYNC_POL : ~H_SYNC_POL;
      vga_v_sync      <= ((yNext >= V_SYNC_BEG) && (yNext < V_SYNC_END)) ? V_SYNC_POL : ~V_SYNC_POL;
      line_start      <= xWrap;
      frame_start     <= yWrap;
    end
  end

`ifdef VGA_TIMING_FRAME_COUNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset)      frame_count <= '0;
    else if (yWrap) frame_count <= frame_count + 16'd1;
  end
`endif

endmodule
